// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit common-anode seven-segment display.
// Double-buffered digit data swaps in only at frame boundaries; all pins are registered.
module seven_seg_scan_ctrl #(
  parameter int DIV  = 100000,
  parameter int DEAD = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        ld,
  input  logic [31:0] ld_data,
  input  logic [7:0]  ld_den,
  input  logic [7:0]  ld_dp,
  output logic        pending,
  output logic        frame_start,
  output logic [7:0]  ss_sel,
  output logic [6:0]  ss_seg,
  output logic        ss_dp
);

  localparam int CNT_MAX = (DIV > DEAD) ? DIV : DEAD;
  localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_DEAD  = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  state_t      r_state;
  logic [2:0]  r_digit;
  logic [CW-1:0] r_cnt;

  logic [31:0] r_sh_data;
  logic [7:0]  r_sh_den;
  logic [7:0]  r_sh_dp;
  logic [31:0] r_ac_data;
  logic [7:0]  r_ac_den;
  logic [7:0]  r_ac_dp;
  logic        r_pending;

  logic        r_frame_start;
  logic [7:0]  r_ss_sel;
  logic [6:0]  r_ss_seg;
  logic        r_ss_dp;

  state_t      w_state_next;
  logic [2:0]  w_digit_next;
  logic [CW-1:0] w_cnt_next;
  logic        w_boundary;
  logic        w_xfer;
  logic        w_pending_next;

  logic [31:0] w_ac_data_next;
  logic [7:0]  w_ac_den_next;
  logic [7:0]  w_ac_dp_next;

  logic [3:0]  w_nib [8];
  logic [7:0]  w_sel_next;
  logic [6:0]  w_seg_next;
  logic        w_dp_next;

  function automatic logic [6:0] hex_decode(input logic [3:0] val);
    logic [6:0] seg;
    case (val)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // Scan sequencer; a boundary is any entry into DEAD for digit 0.
  always_comb begin
    w_state_next = r_state;
    w_digit_next = r_digit;
    w_cnt_next   = r_cnt;
    w_boundary   = 1'b0;
    if (!en) begin
      w_state_next = ST_OFF;
      w_digit_next = 3'd0;
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        ST_OFF: begin
          w_state_next = ST_DEAD;
          w_digit_next = 3'd0;
          w_cnt_next   = '0;
          w_boundary   = 1'b1;
        end
        ST_DEAD: begin
          if (r_cnt == CW'(DEAD - 1)) begin
            w_state_next = ST_DRIVE;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + CW'(1);
          end
        end
        ST_DRIVE: begin
          if (r_cnt == CW'(DIV - 1)) begin
            w_state_next = ST_DEAD;
            w_digit_next = r_digit + 3'd1;
            w_cnt_next   = '0;
            w_boundary   = (r_digit == 3'd7);
          end else begin
            w_cnt_next = r_cnt + CW'(1);
          end
        end
        default: begin
          w_state_next = ST_OFF;
          w_digit_next = 3'd0;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  // A load on the boundary edge lands in the shadow set after the old shadow moves to active.
  assign w_xfer         = w_boundary & r_pending;
  assign w_pending_next = ld | (r_pending & ~w_xfer);
  assign w_ac_data_next = w_xfer ? r_sh_data : r_ac_data;
  assign w_ac_den_next  = w_xfer ? r_sh_den  : r_ac_den;
  assign w_ac_dp_next   = w_xfer ? r_sh_dp   : r_ac_dp;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_nib
      assign w_nib[gi] = w_ac_data_next[4*gi +: 4];
    end
  endgenerate

  // Pins are decoded from next-state so they change together with the state register.
  always_comb begin
    w_sel_next = 8'hFF;
    w_seg_next = 7'h7F;
    w_dp_next  = 1'b1;
    if (w_state_next == ST_DRIVE) begin
      w_sel_next = w_ac_den_next[w_digit_next] ? ~(8'b1 << w_digit_next) : 8'hFF;
      w_seg_next = hex_decode(w_nib[w_digit_next]);
      w_dp_next  = ~w_ac_dp_next[w_digit_next];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_OFF;
      r_digit <= 3'd0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_digit <= w_digit_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_data <= 32'h0;
      r_sh_den  <= 8'h0;
      r_sh_dp   <= 8'h0;
      r_ac_data <= 32'h0;
      r_ac_den  <= 8'h0;
      r_ac_dp   <= 8'h0;
      r_pending <= 1'b0;
    end else begin
      if (ld) begin
        r_sh_data <= ld_data;
        r_sh_den  <= ld_den;
        r_sh_dp   <= ld_dp;
      end
      r_ac_data <= w_ac_data_next;
      r_ac_den  <= w_ac_den_next;
      r_ac_dp   <= w_ac_dp_next;
      r_pending <= w_pending_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_start <= 1'b0;
      r_ss_sel      <= 8'hFF;
      r_ss_seg      <= 7'h7F;
      r_ss_dp       <= 1'b1;
    end else begin
      r_frame_start <= w_boundary;
      r_ss_sel      <= w_sel_next;
      r_ss_seg      <= w_seg_next;
      r_ss_dp       <= w_dp_next;
    end
  end

  assign pending     = r_pending;
  assign frame_start = r_frame_start;
  assign ss_sel      = r_ss_sel;
  assign ss_seg      = r_ss_seg;
  assign ss_dp       = r_ss_dp;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with DIV=4, DEAD=2: every cycle of each
// observed frame is compared against hand-computed digit patterns.
module tb_seven_seg_scan_ctrl;

  localparam int DIV   = 4;
  localparam int DEAD  = 2;
  localparam int SLOT  = DIV + DEAD;
  localparam int FRAME = 8 * SLOT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        ld = 1'b0;
  logic [31:0] ld_data = 32'h0;
  logic [7:0]  ld_den = 8'h0;
  logic [7:0]  ld_dp = 8'h0;
  logic        pending;
  logic        frame_start;
  logic [7:0]  ss_sel;
  logic [6:0]  ss_seg;
  logic        ss_dp;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  den;
    logic [7:0]  dp;
  } load_t;

  typedef struct packed {
    logic [7:0][7:0] sel;
    logic [7:0][6:0] seg;
    logic [7:0]      ndp;
  } disp_t;

  typedef struct {
    disp_t exp;
    int    ld_at;
    load_t ldv;
  } vec_t;

  seven_seg_scan_ctrl #(.DIV(DIV), .DEAD(DEAD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .ld          (ld),
    .ld_data     (ld_data),
    .ld_den      (ld_den),
    .ld_dp       (ld_dp),
    .pending     (pending),
    .frame_start (frame_start),
    .ss_sel      (ss_sel),
    .ss_seg      (ss_seg),
    .ss_dp       (ss_dp)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] e_sel, input logic [6:0] e_seg,
                       input logic e_dp, input logic e_fs, input logic e_pend);
    n_checks++;
    if ({ss_sel, ss_seg, ss_dp, frame_start, pending} !== {e_sel, e_seg, e_dp, e_fs, e_pend}) begin
      n_fail++;
      $display("FAIL %s: got sel=%h seg=%h dp=%b fs=%b pend=%b, want sel=%h seg=%h dp=%b fs=%b pend=%b",
               name, ss_sel, ss_seg, ss_dp, frame_start, pending, e_sel, e_seg, e_dp, e_fs, e_pend);
    end
  endtask

  task automatic apply_load(input load_t v);
    ld      = 1'b1;
    ld_data = v.data;
    ld_den  = v.den;
    ld_dp   = v.dp;
  endtask

  // Entered at the sampling point of a frame's first cycle; leaves at cycle ncyc.
  task automatic scan_frame(input string tag, input disp_t exp, input logic pend_in,
                            input int ld_a_at, input load_t ld_a,
                            input int ld_b_at, input load_t ld_b, input int ncyc);
    logic pend_e;
    pend_e = pend_in;
    for (int c = 0; c < ncyc; c++) begin
      int d;
      int ph;
      d  = c / SLOT;
      ph = c % SLOT;
      if (ph < DEAD)
        check($sformatf("%s c%0d", tag, c), 8'hFF, 7'h7F, 1'b1, (c == 0), pend_e);
      else
        check($sformatf("%s c%0d", tag, c), exp.sel[d], exp.seg[d], exp.ndp[d], 1'b0, pend_e);
      if (c == ld_a_at)      apply_load(ld_a);
      else if (c == ld_b_at) apply_load(ld_b);
      else                   ld = 1'b0;
      if (c == ld_a_at || c == ld_b_at) pend_e = 1'b1;
      @(negedge clk);
    end
    ld = 1'b0;
    $display("frame %s: %0d cycles compared", tag, ncyc);
  endtask

  load_t L0, L1, L2, L3, LNONE;
  disp_t D_BLANK, D0, D1, D2, D3;
  vec_t  tv [3];

  initial begin
    L0    = '{data: 32'h7654_3210, den: 8'hFF, dp: 8'h00};
    L1    = '{data: 32'hFEDC_BA98, den: 8'hFF, dp: 8'h00};
    L2    = '{data: 32'h7654_3210, den: 8'h0F, dp: 8'h81};
    L3    = '{data: 32'h0A5C_3E1F, den: 8'hAA, dp: 8'h55};
    LNONE = '{data: 32'h0, den: 8'h0, dp: 8'h0};

    D_BLANK.sel = {8{8'hFF}};
    D_BLANK.seg = {8{7'h40}};
    D_BLANK.ndp = 8'hFF;

    D0.sel = {8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
    D0.seg = {7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
    D0.ndp = 8'hFF;

    D1.sel = {8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
    D1.seg = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};
    D1.ndp = 8'hFF;

    D2.sel = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
    D2.seg = {7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
    D2.ndp = 8'h7E;

    D3.sel = {8'h7F, 8'hFF, 8'hDF, 8'hFF, 8'hF7, 8'hFF, 8'hFD, 8'hFF};
    D3.seg = {7'h40, 7'h08, 7'h12, 7'h46, 7'h30, 7'h06, 7'h79, 7'h0E};
    D3.ndp = 8'hAA;

    // Each entry: frame contents expected, plus a load issued during that frame.
    tv[0].exp = D0; tv[0].ld_at = 21; tv[0].ldv = L1;  // digit 3 driving
    tv[1].exp = D1; tv[1].ld_at = 5;  tv[1].ldv = L2;
    tv[2].exp = D2; tv[2].ld_at = 40; tv[2].ldv = L3;

    repeat (3) @(negedge clk);
    check("reset", 8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("off idle", 8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0);
    end

    // Load and enable on the same edge: first frame still shows reset contents.
    apply_load(L0);
    en = 1'b1;
    @(negedge clk);
    ld = 1'b0;
    scan_frame("blank", D_BLANK, 1'b1, -1, LNONE, -1, LNONE, FRAME);

    for (int k = 0; k < 3; k++)
      scan_frame($sformatf("vec%0d", k), tv[k].exp, 1'b0, tv[k].ld_at, tv[k].ldv, -1, LNONE, FRAME);

    // Collision: pending shadow L0 moves to active while L1 lands in shadow.
    scan_frame("collide-pre", D3, 1'b0, 30, L0, 47, L1, FRAME);
    scan_frame("collide-mid", D0, 1'b1, -1, LNONE, -1, LNONE, FRAME);
    scan_frame("collide-post", D1, 1'b0, -1, LNONE, -1, LNONE, 34);

    // Disable while digit 5 is driving.
    en = 1'b0;
    @(negedge clk);
    check("disable", 8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("off hold", 8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0);
    end
    en = 1'b1;
    @(negedge clk);
    scan_frame("reenable", D1, 1'b0, 5, L2, -1, LNONE, 20);
    check("pre-reset drive", 8'hF7, 7'h03, 1'b1, 1'b0, 1'b1);

    // Asynchronous reset between clock edges.
    #2 rst_n = 1'b0;
    #1 check("async reset", 8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post reset off", 8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0);
    en = 1'b1;
    @(negedge clk);
    scan_frame("after reset", D_BLANK, 1'b0, -1, LNONE, -1, LNONE, FRAME);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
# seven_seg_scan_ctrl

Time-multiplexed scan controller for the board's 8-digit, common-anode seven-segment display. It holds a 32-bit display value as eight hex nibbles, plus per-digit enable and decimal-point masks, loaded from the memory-mapped I/O path. It steps through the eight anodes with a programmable on-time and a dead-time between digits to suppress ghosting. New values are double-buffered and take effect only at a frame boundary, so a frame never shows a mix of old and new digits.

## Interface
Parameters:
- DIV, default 100000: cycles each digit is driven, ≥2.
- DEAD, default 16: all-off cycles before each digit, ≥1.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  scan enable; low forces the display off.
- ld  in  1  one-cycle load strobe from the I/O bus.
- ld_data  in  32  nibble i = bits [4i+3:4i], shown on digit i.
- ld_den  in  8  digit enable mask; 0 keeps that anode off.
- ld_dp  in  8  decimal point mask; 1 lights the DP.
- pending  out  1  shadow registers hold data not yet displayed.
- frame_start  out  1  one-cycle pulse at each frame boundary.
- ss_sel  out  8  anode selects, active-low; bit i is digit i.
- ss_seg  out  7  segments gfedcba, active-low; bit 0 is a.
- ss_dp  out  1  decimal point, active-low.

## Operation
- Registers:
  - shadow set {sh_data, sh_den, sh_dp}.
  - active set {ac_data, ac_den, ac_dp}.
  - state: OFF, DEAD or DRIVE.
  - digit index, 3 bits.
  - cycle counter, sized for max(DIV, DEAD).
- Reset values: state OFF, digit 0, counter 0, all shadow and active registers 0, pending 0, frame_start 0, ss_sel 8'hFF, ss_seg 7'h7F, ss_dp 1.
- OFF:
  - outputs are in the off pattern (ss_sel FF, ss_seg 7F, ss_dp 1).
  - en=1 moves to DEAD with digit 0 and counter 0.
- DEAD:
  - outputs are in the off pattern.
  - after DEAD cycles, moves to DRIVE with counter 0.
- DRIVE:
  - ss_sel is ~(8'b1<<digit) if ac_den[digit], otherwise FF.
  - ss_seg is hex_decode(ac_data[4·digit+:4]); ss_dp is ~ac_dp[digit].
  - after DIV cycles, digit becomes digit+1 mod 8 and the state moves to DEAD.
  - the 7→0 wrap is a frame boundary.
- Frame boundary: any entry into DEAD with digit 0, whether from OFF or from the wrap.
  - frame_start is 1 during that first DEAD cycle.
  - if pending=1 on the boundary edge, the active set is loaded from the shadow set and pending clears.
- Load:
  - ld=1 writes the ld_* inputs into the shadow set and sets pending.
  - a later ld before the boundary overwrites the shadow set (last write wins).
  - ld on the same edge as a boundary transfer: the active set takes the previous shadow contents, the shadow set takes the new ld_* values, and pending stays 1.
- en=0 in any state moves to OFF on the next edge, with the off pattern in that same cycle.
  - digit and counter reset to 0.
  - shadow, active and pending are retained.
  - a later en=1 restarts at a frame boundary.
- hex_decode table, as gfedcba hex:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78.
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E.
- All outputs are flops, decoded from next-state, so their value always matches the state held in that cycle; no combinational glitches reach the pins.

## Timing
- Digit slot is DEAD+DIV cycles; frame is 8·(DEAD+DIV) cycles.
- If en is first seen high on edge k:
  - DEAD (digit 0) runs from cycle k+1, with frame_start in cycle k+1.
  - digit 0 drives from cycle k+1+DEAD.
- Load to display latency: from the ld edge to the next boundary, at most one frame plus the current slot.
- pending rises the cycle after ld and falls the cycle after the transfer edge.
- An asynchronous rst_n assertion mid-frame forces the reset values immediately; after release, the block starts in OFF.

## Test plan
Benches run with DIV=4, DEAD=2.
- Enable and scan: reset, then ld_data=32'h76543210, ld_den=FF, ld_dp=00, then en=1.
  - first frame still shows the reset (blank) contents.
  - the second frame shows digit i with segment code of value i; ss_sel steps FE, FD … 7F.
  - each digit slot is 2 off cycles followed by 4 drive cycles.
- Double buffering: ld while digit 3 is driving.
  - digits 3–7 of that frame keep the old value.
  - pending stays 1 until the next frame_start, and the new value appears from digit 0.
- Masks: ld_den=8'h0F, ld_dp=8'h81.
  - ss_sel stays FF for digits 4–7.
  - ss_dp is 0 only while digits 0 and 7 are driven.
- Load collision: ld on the exact frame-boundary edge.
  - active takes the prior shadow values.
  - the new values appear one frame later; pending is 1 between.
- Disable: en=0 during DRIVE of digit 5.
  - next cycle shows the off pattern (FF, 7F, 1).
  - re-enabling restarts at digit 0 with a frame_start pulse.
- Reset: assert rst_n low mid-DRIVE.
  - outputs go to FF, 7F, 1 and pending to 0 with no clock edge.
  - hex decode of all values 0–F matches the table.
